// File: rtl/lsu_mo.sv
// lsu_mo: multi-outstanding load/store unit.
// Accepts memory operations from EX1, issues them to the MMU/D-cache port and
// keeps up to DEPTH operations in flight or buffered at once. Results come back
// in request order, are shifted and extended, and then wait in a result FIFO
// until the consumer takes them. A cancel flushes all pending work. Read data
// that is still owed for flushed requests is dropped when it arrives.
//
// Encodings:
//   mem_type  : 0 = MEM_LOAD_S, 1 = MEM_LOAD_U, 2 = MEM_STORE
//   mem_size  : 0 = MEM_BYTE,   1 = MEM_HALF,   2 = MEM_WORD
//   excp_type : 0 = ALE, 1 = TLBR, 2 = PIL, 3 = PIS, 4 = PPI, 5 = PME
//
// Ports:
//   clk, reset (async, active-low), cancel (pipeline flush)
//   req_valid/req_ready, base, offset, mem_type, mem_size, st_data : EX1 request
//   have_excp, excp_type : combinational exception report for the current request
//   ok, accept_ok, ld_data : result FIFO head and its pop handshake
//   mmu_req, mmu_addr, mmu_we, mmu_size, mmu_wstrb, mmu_wdata : MMU request
//   mmu_addr_ok, mmu_data_ok, mmu_rdata : MMU handshakes and read data
//   mmu_tlbr, mmu_pil, mmu_pis, mmu_ppi, mmu_pme : translation faults for mmu_addr
//   occupancy : operations in flight plus results buffered
module lsu_mo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cancel,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      base,
  input  logic [31:0]      offset,
  input  logic [1:0]       mem_type,
  input  logic [1:0]       mem_size,
  input  logic [31:0]      st_data,
  output logic             have_excp,
  output logic [2:0]       excp_type,
  output logic             ok,
  input  logic             accept_ok,
  output logic [31:0]      ld_data,
  output logic             mmu_req,
  output logic [31:0]      mmu_addr,
  output logic             mmu_we,
  output logic [1:0]       mmu_size,
  output logic [3:0]       mmu_wstrb,
  output logic [31:0]      mmu_wdata,
  input  logic             mmu_addr_ok,
  input  logic             mmu_data_ok,
  input  logic [31:0]      mmu_rdata,
  input  logic             mmu_tlbr,
  input  logic             mmu_pil,
  input  logic             mmu_pis,
  input  logic             mmu_ppi,
  input  logic             mmu_pme,
  output logic [CNT_W-1:0] occupancy
);

  localparam logic [1:0] MEM_LOAD_S = 2'd0;
  localparam logic [1:0] MEM_STORE  = 2'd2;
  localparam logic [1:0] MEM_BYTE   = 2'd0;
  localparam logic [1:0] MEM_HALF   = 2'd1;
  localparam logic [1:0] MEM_WORD   = 2'd2;

  localparam logic [2:0] EXC_ALE  = 3'd0;
  localparam logic [2:0] EXC_TLBR = 3'd1;
  localparam logic [2:0] EXC_PIL  = 3'd2;
  localparam logic [2:0] EXC_PIS  = 3'd3;
  localparam logic [2:0] EXC_PPI  = 3'd4;
  localparam logic [2:0] EXC_PME  = 3'd5;

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [1:0] low;
    logic [1:0] size;
    logic       sgn;
    logic       st;
  } trk_t;

  logic [31:0]      addr;
  logic             issue;
  logic             trk_pop;
  logic             res_push;
  logic             res_pop;
  logic             drop_act;
  logic [AW:0]      trk_cnt;
  logic [CNT_W-1:0] cancel_drop;
  trk_t             head;
  logic [31:0]      shifted;
  logic [31:0]      load_val;

  trk_t             trk_q [DEPTH];
  trk_t             trk_d [DEPTH];
  logic [AW:0]      trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
  logic [31:0]      res_q [DEPTH];
  logic [31:0]      res_d [DEPTH];
  logic [AW:0]      res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CNT_W-1:0] occ_q, occ_d, drop_q, drop_d;

  assign addr     = base + offset;
  assign mmu_addr = addr;

  always_comb begin
    have_excp = 1'b0;
    excp_type = EXC_ALE;
    if (req_valid) begin
      if ((mem_size == MEM_HALF && addr[0]) ||
          (mem_size == MEM_WORD && addr[1:0] != 2'b00)) begin
        have_excp = 1'b1;
        excp_type = EXC_ALE;
      end else if (mmu_tlbr) begin
        have_excp = 1'b1;
        excp_type = EXC_TLBR;
      end else if (mmu_pil) begin
        have_excp = 1'b1;
        excp_type = EXC_PIL;
      end else if (mmu_pis) begin
        have_excp = 1'b1;
        excp_type = EXC_PIS;
      end else if (mmu_ppi) begin
        have_excp = 1'b1;
        excp_type = EXC_PPI;
      end else if (mmu_pme) begin
        have_excp = 1'b1;
        excp_type = EXC_PME;
      end
    end
  end

  // occ_q already counts the result slot each in-flight request will need,
  // so a grant never has to wait for FIFO space when its data returns.
  assign mmu_req   = reset && req_valid && !have_excp && (occ_q < DEPTH_C) && !cancel;
  assign issue     = mmu_req && mmu_addr_ok;
  assign req_ready = reset && (issue || (req_valid && have_excp));

  always_comb begin
    mmu_size  = mem_size;
    mmu_we    = (mem_type == MEM_STORE);
    mmu_wstrb = 4'b0000;
    mmu_wdata = 32'h0;
    if (mem_type == MEM_STORE) begin
      case (mem_size)
        MEM_BYTE: begin
          mmu_wstrb = 4'b0001 << addr[1:0];
          mmu_wdata = {4{st_data[7:0]}};
        end
        MEM_HALF: begin
          mmu_wstrb = addr[1] ? 4'b1100 : 4'b0011;
          mmu_wdata = {2{st_data[15:0]}};
        end
        default: begin
          mmu_wstrb = 4'b1111;
          mmu_wdata = st_data;
        end
      endcase
    end
  end

  assign trk_cnt  = trk_wr_q - trk_rd_q;
  assign trk_pop  = mmu_data_ok && (trk_cnt != '0);
  assign drop_act = (drop_q != '0);
  assign res_push = trk_pop && !cancel && !drop_act;
  assign ok       = (res_wr_q != res_rd_q);
  assign res_pop  = ok && accept_ok && !cancel;
  // A data_ok arriving in the cancel cycle retires one entry right away, so it
  // is not counted among the returns that still have to be dropped.
  assign cancel_drop = CNT_W'(trk_cnt) - CNT_W'(trk_pop);

  assign head    = trk_q[trk_rd_q[AW-1:0]];
  assign shifted = mmu_rdata >> {head.low, 3'b000};

  always_comb begin
    load_val = shifted;
    case (head.size)
      MEM_BYTE: load_val = {{24{head.sgn & shifted[7]}}, shifted[7:0]};
      MEM_HALF: load_val = {{16{head.sgn & shifted[15]}}, shifted[15:0]};
      default:  load_val = shifted;
    endcase
    if (head.st) begin
      load_val = 32'h0;
    end
  end

  always_comb begin
    trk_d    = trk_q;
    trk_wr_d = trk_wr_q;
    trk_rd_d = trk_rd_q;
    res_d    = res_q;
    res_wr_d = res_wr_q;
    res_rd_d = res_rd_q;
    occ_d    = occ_q;
    drop_d   = drop_q;

    if (issue) begin
      trk_d[trk_wr_q[AW-1:0]].low  = addr[1:0];
      trk_d[trk_wr_q[AW-1:0]].size = mem_size;
      trk_d[trk_wr_q[AW-1:0]].sgn  = (mem_type == MEM_LOAD_S);
      trk_d[trk_wr_q[AW-1:0]].st   = (mem_type == MEM_STORE);
      trk_wr_d = trk_wr_q + 1'b1;
    end
    if (trk_pop) begin
      trk_rd_d = trk_rd_q + 1'b1;
    end
    if (res_push) begin
      res_d[res_wr_q[AW-1:0]] = load_val;
      res_wr_d = res_wr_q + 1'b1;
    end
    if (res_pop) begin
      res_rd_d = res_rd_q + 1'b1;
    end

    if (cancel) begin
      res_wr_d = '0;
      res_rd_d = '0;
      drop_d   = cancel_drop;
      occ_d    = cancel_drop;
    end else begin
      if (trk_pop && drop_act) begin
        drop_d = drop_q - 1'b1;
      end
      occ_d = occ_q + CNT_W'(issue) - CNT_W'(res_pop) - CNT_W'(trk_pop && drop_act);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        trk_q[i] <= '0;
        res_q[i] <= '0;
      end
      trk_wr_q <= '0;
      trk_rd_q <= '0;
      res_wr_q <= '0;
      res_rd_q <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
    end else begin
      trk_q    <= trk_d;
      res_q    <= res_d;
      trk_wr_q <= trk_wr_d;
      trk_rd_q <= trk_rd_d;
      res_wr_q <= res_wr_d;
      res_rd_q <= res_rd_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end

  assign ld_data   = ok ? res_q[res_rd_q[AW-1:0]] : 32'h0;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_lsu_mo.sv
module tb_lsu_mo;

  localparam logic [1:0] LOAD_S = 2'd0, LOAD_U = 2'd1, STORE = 2'd2;
  localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;
  localparam logic [2:0] ALE = 3'd0, TLBR = 3'd1, PPI = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cancel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] base = '0, offset = '0, st_data = '0;
  logic [1:0]  mem_type = '0, mem_size = '0;
  logic        have_excp;
  logic [2:0]  excp_type;
  logic        ok;
  logic        accept_ok = 1'b0;
  logic [31:0] ld_data;
  logic        mmu_req, mmu_we;
  logic [31:0] mmu_addr, mmu_wdata;
  logic [1:0]  mmu_size;
  logic [3:0]  mmu_wstrb;
  logic        mmu_addr_ok = 1'b1, mmu_data_ok = 1'b0;
  logic [31:0] mmu_rdata = '0;
  logic        mmu_tlbr = 0, mmu_pil = 0, mmu_pis = 0, mmu_ppi = 0, mmu_pme = 0;
  logic [2:0]  occupancy;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  lsu_mo #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cancel(cancel),
    .req_valid(req_valid), .req_ready(req_ready),
    .base(base), .offset(offset), .mem_type(mem_type), .mem_size(mem_size),
    .st_data(st_data), .have_excp(have_excp), .excp_type(excp_type),
    .ok(ok), .accept_ok(accept_ok), .ld_data(ld_data),
    .mmu_req(mmu_req), .mmu_addr(mmu_addr), .mmu_we(mmu_we), .mmu_size(mmu_size),
    .mmu_wstrb(mmu_wstrb), .mmu_wdata(mmu_wdata),
    .mmu_addr_ok(mmu_addr_ok), .mmu_data_ok(mmu_data_ok), .mmu_rdata(mmu_rdata),
    .mmu_tlbr(mmu_tlbr), .mmu_pil(mmu_pil), .mmu_pis(mmu_pis),
    .mmu_ppi(mmu_ppi), .mmu_pme(mmu_pme), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // MMU stand-in: each grant takes the next value from rd_src and returns it
  // lat cycles later, in order, one per cycle; hold_data stalls returns.
  int          cyc = 0;
  int          lat = 2;
  bit          hold_data = 0;
  logic [31:0] rd_src[$];
  logic [31:0] pend_d[$];
  int          pend_due[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_d.delete();
      pend_due.delete();
      mmu_data_ok = 1'b0;
    end else begin
      if (mmu_data_ok && pend_d.size() > 0) begin
        void'(pend_d.pop_front());
        void'(pend_due.pop_front());
      end
      if (mmu_req && mmu_addr_ok) begin
        if (rd_src.size() > 0) pend_d.push_back(rd_src.pop_front());
        else pend_d.push_back(32'h0);
        pend_due.push_back(cyc + lat);
      end
      cyc++;
      #2;
      if (!hold_data && pend_d.size() > 0 && pend_due[0] <= cyc) begin
        mmu_data_ok = 1'b1;
        mmu_rdata   = pend_d[0];
      end else begin
        mmu_data_ok = 1'b0;
      end
    end
  end

  task automatic drive_op(input logic [1:0] t, input logic [1:0] s, input logic [31:0] b,
                          input logic [31:0] o, input logic [31:0] d, output bit done);
    mem_type = t; mem_size = s; base = b; offset = o; st_data = d;
    req_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_ok(output bit got, output logic [31:0] d);
    got = 0;
    d = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ok) begin
        got = 1;
        d = ld_data;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1; mem_type = LOAD_U; mem_size = WORD; base = 32'h100; offset = 0;
    repeat (2) @(negedge clk);
    tot_cnt++; if (ok !== 1'b0) $display("FAIL reset_ok got=%b want=0", ok); else pass_cnt++;
    tot_cnt++; if (ld_data !== 32'h0) $display("FAIL reset_ld_data got=%h want=0", ld_data); else pass_cnt++;
    tot_cnt++; if (occupancy !== 3'd0) $display("FAIL reset_occ got=%0d want=0", occupancy); else pass_cnt++;
    tot_cnt++; if (mmu_req !== 1'b0) $display("FAIL reset_mmu_req got=%b want=0", mmu_req); else pass_cnt++;
    tot_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b want=0", req_ready); else pass_cnt++;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exceptions();
    bit saw_ok = 0;
    mmu_addr_ok = 1'b1;
    req_valid = 1'b1; mem_type = LOAD_U; mem_size = WORD; base = 32'h3000; offset = 32'h1;
    @(negedge clk);
    tot_cnt++; if (have_excp !== 1'b1) $display("FAIL ale_have_excp got=%b want=1", have_excp); else pass_cnt++;
    tot_cnt++; if (excp_type !== ALE) $display("FAIL ale_type got=%0d want=%0d", excp_type, ALE); else pass_cnt++;
    tot_cnt++; if (req_ready !== 1'b1) $display("FAIL ale_req_ready got=%b want=1", req_ready); else pass_cnt++;
    tot_cnt++; if (mmu_req !== 1'b0) $display("FAIL ale_mmu_req got=%b want=0", mmu_req); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ok || occupancy != 0) saw_ok = 1;
      @(posedge clk); #1;
    end
    tot_cnt++; if (saw_ok !== 1'b0) $display("FAIL ale_no_ok got=%b want=0", saw_ok); else pass_cnt++;

    req_valid = 1'b1; mem_size = WORD; offset = 32'h0; mmu_tlbr = 1; mmu_pil = 1;
    @(negedge clk);
    tot_cnt++; if (have_excp !== 1'b1 || excp_type !== TLBR)
      $display("FAIL tlbr_prio got=%b/%0d want=1/%0d", have_excp, excp_type, TLBR); else pass_cnt++;
    tot_cnt++; if (mmu_req !== 1'b0) $display("FAIL tlbr_mmu_req got=%b want=0", mmu_req); else pass_cnt++;
    @(posedge clk); #1;
    mem_size = HALF; offset = 32'h1;
    @(negedge clk);
    tot_cnt++; if (excp_type !== ALE) $display("FAIL ale_over_tlbr got=%0d want=%0d", excp_type, ALE); else pass_cnt++;
    @(posedge clk); #1;
    mmu_tlbr = 0; mmu_pil = 0; mmu_ppi = 1; mem_size = WORD; offset = 32'h0;
    @(negedge clk);
    tot_cnt++; if (have_excp !== 1'b1 || excp_type !== PPI)
      $display("FAIL ppi got=%b/%0d want=1/%0d", have_excp, excp_type, PPI); else pass_cnt++;
    @(posedge clk); #1;
    mmu_ppi = 0; mmu_addr_ok = 1'b0;
    @(negedge clk);
    tot_cnt++; if (have_excp !== 1'b0 || excp_type !== ALE)
      $display("FAIL clean_excp got=%b/%0d want=0/%0d", have_excp, excp_type, ALE); else pass_cnt++;
    tot_cnt++; if (mmu_req !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL stall_no_addr_ok got=%b/%b want=1/0", mmu_req, req_ready); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0; offset = 32'h1;
    @(negedge clk);
    tot_cnt++; if (have_excp !== 1'b0) $display("FAIL excp_needs_valid got=%b want=0", have_excp); else pass_cnt++;
    @(posedge clk); #1;
    mmu_addr_ok = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    int got = 0, first = -1, last = -1, idx = 0;
    logic [2:0] peak = 0;
    for (int i = 0; i < 4; i++) rd_src.push_back(exp_d[i]);
    lat = 2; accept_ok = 1'b1;
    req_valid = 1'b1; mem_type = LOAD_U; mem_size = WORD; base = 32'h1000; offset = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (idx < 4) begin
        tot_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_issue%0d got=%b want=1", idx, req_ready); else pass_cnt++;
      end
      if (ok) begin
        if (got < 4) begin
          tot_cnt++; if (ld_data !== exp_d[got])
            $display("FAIL b2b_data%0d got=%h want=%h", got, ld_data, exp_d[got]); else pass_cnt++;
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (occupancy > peak) peak = occupancy;
      @(posedge clk); #1;
      if (idx < 4) idx++;
      if (idx < 4) offset = 32'(idx * 4);
      else req_valid = 1'b0;
    end
    tot_cnt++; if (got != 4) $display("FAIL b2b_count got=%0d want=4", got); else pass_cnt++;
    tot_cnt++; if (last - first != 3) $display("FAIL b2b_consecutive got=%0d want=3", last - first); else pass_cnt++;
    tot_cnt++; if (peak !== 3'd3) $display("FAIL b2b_peak_occ got=%0d want=3", peak); else pass_cnt++;
    tot_cnt++; if (occupancy !== 3'd0) $display("FAIL b2b_final_occ got=%0d want=0", occupancy); else pass_cnt++;
  endtask

  task automatic test_extension();
    logic [1:0]  ty[4] = '{LOAD_S, LOAD_U, LOAD_S, LOAD_U};
    logic [1:0]  sz[4] = '{BYTE, HALF, HALF, BYTE};
    logic [31:0] of[4] = '{32'h3, 32'h2, 32'h2, 32'h1};
    logic [31:0] ex[4] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_00FF};
    bit done, got;
    logic [31:0] d;
    accept_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_src.push_back(32'h80FF_FF00);
      drive_op(ty[i], sz[i], 32'h1000, of[i], 32'h0, done);
      wait_ok(got, d);
      tot_cnt++; if (!done || !got || d !== ex[i])
        $display("FAIL ext%0d got=%h (issued=%b ok=%b) want=%h", i, d, done, got, ex[i]); else pass_cnt++;
    end
  endtask

  task automatic test_store();
    logic [1:0]  ty[4] = '{STORE, STORE, STORE, LOAD_U};
    logic [1:0]  sz[4] = '{HALF, BYTE, WORD, WORD};
    logic [31:0] of[4] = '{32'h2, 32'h1, 32'h4, 32'h8};
    logic [31:0] sd[4] = '{32'h1234_ABCD, 32'h0000_00AB, 32'hCAFE_F00D, 32'h0};
    logic [3:0]  es[4] = '{4'b1100, 4'b0010, 4'b1111, 4'b0000};
    logic [31:0] ew[4] = '{32'hABCD_ABCD, 32'hABAB_ABAB, 32'hCAFE_F00D, 32'h0};
    logic        ewe[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    logic [31:0] el[4] = '{32'h0, 32'h0, 32'h0, 32'h0BAD_F00D};
    bit got;
    logic [31:0] d;
    accept_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_src.push_back(rd[i]);
      mem_type = ty[i]; mem_size = sz[i]; base = 32'h2000; offset = of[i]; st_data = sd[i];
      req_valid = 1'b1;
      @(negedge clk);
      tot_cnt++; if (mmu_req !== 1'b1 || mmu_we !== ewe[i] || mmu_size !== sz[i] || mmu_addr !== 32'h2000 + of[i])
        $display("FAIL st%0d_req got=%b/%b/%0d/%h want=1/%b/%0d/%h", i, mmu_req, mmu_we, mmu_size, mmu_addr,
                 ewe[i], sz[i], 32'h2000 + of[i]); else pass_cnt++;
      tot_cnt++; if (mmu_wstrb !== es[i]) $display("FAIL st%0d_wstrb got=%b want=%b", i, mmu_wstrb, es[i]); else pass_cnt++;
      if (ewe[i]) begin
        tot_cnt++; if (mmu_wdata !== ew[i]) $display("FAIL st%0d_wdata got=%h want=%h", i, mmu_wdata, ew[i]); else pass_cnt++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_ok(got, d);
      tot_cnt++; if (!got || d !== el[i]) $display("FAIL st%0d_result got=%h (ok=%b) want=%h", i, d, got, el[i]); else pass_cnt++;
    end
  endtask

  task automatic test_full();
    logic [31:0] fd[5] = '{32'hF000_0000, 32'hF111_1111, 32'hF222_2222, 32'hF333_3333, 32'hF444_4444};
    int grants = 0, idx = 0;
    bit cons, got;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) rd_src.push_back(fd[i]);
    accept_ok = 1'b0; lat = 2;
    req_valid = 1'b1; mem_type = LOAD_U; mem_size = WORD; base = 32'h5000; offset = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mmu_req && mmu_addr_ok) grants++;
      cons = req_ready;
      @(posedge clk); #1;
      if (cons) begin
        idx++;
        offset = 32'(idx * 4);
      end
    end
    @(negedge clk);
    tot_cnt++; if (grants != 4 || idx != 4) $display("FAIL full_grants got=%0d/%0d want=4/4", grants, idx); else pass_cnt++;
    tot_cnt++; if (mmu_req !== 1'b0 || occupancy !== 3'd4)
      $display("FAIL full_stall got=%b/%0d want=0/4", mmu_req, occupancy); else pass_cnt++;
    @(posedge clk); #1;
    accept_ok = 1'b1;
    @(negedge clk);
    tot_cnt++; if (ok !== 1'b1 || ld_data !== fd[0]) $display("FAIL full_head got=%b/%h want=1/%h", ok, ld_data, fd[0]); else pass_cnt++;
    tot_cnt++; if (mmu_req !== 1'b0) $display("FAIL full_pop_cycle_req got=%b want=0", mmu_req); else pass_cnt++;
    @(posedge clk); #1;
    accept_ok = 1'b0;
    @(negedge clk);
    tot_cnt++; if (mmu_req !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL full_restart got=%b/%b want=1/1", mmu_req, req_ready); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    accept_ok = 1'b1;
    for (int i = 1; i < 5; i++) begin
      wait_ok(got, d);
      tot_cnt++; if (!got || d !== fd[i]) $display("FAIL full_drain%0d got=%h (ok=%b) want=%h", i, d, got, fd[i]); else pass_cnt++;
    end
    tot_cnt++; if (occupancy !== 3'd0) $display("FAIL full_final_occ got=%0d want=0", occupancy); else pass_cnt++;
  endtask

  task automatic test_cancel();
    bit done, got, extra = 0;
    logic [31:0] d;
    accept_ok = 1'b0; hold_data = 0;
    rd_src.push_back(32'h5555_0001);
    drive_op(LOAD_U, WORD, 32'h6000, 32'h0, 32'h0, done);
    wait_ok(got, d);
    hold_data = 1;
    rd_src.push_back(32'hAAAA_0001);
    rd_src.push_back(32'hAAAA_0002);
    rd_src.push_back(32'hAAAA_0003);
    for (int i = 1; i < 4; i++) drive_op(LOAD_U, WORD, 32'h6000, 32'(i * 4), 32'h0, done);
    @(negedge clk);
    tot_cnt++; if (ok !== 1'b1 || occupancy !== 3'd4)
      $display("FAIL cancel_pre got=%b/%0d want=1/4", ok, occupancy); else pass_cnt++;
    @(posedge clk); #1;
    rd_src.push_back(32'h7777_0007);
    cancel = 1'b1; accept_ok = 1'b1;
    req_valid = 1'b1; mem_type = LOAD_U; mem_size = WORD; base = 32'h6100; offset = 0;
    @(negedge clk);
    tot_cnt++; if (mmu_req !== 1'b0) $display("FAIL cancel_gates_req got=%b want=0", mmu_req); else pass_cnt++;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    tot_cnt++; if (ok !== 1'b0 || occupancy !== 3'd3)
      $display("FAIL cancel_flush got=%b/%0d want=0/3", ok, occupancy); else pass_cnt++;
    tot_cnt++; if (mmu_req !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL cancel_reissue got=%b/%b want=1/1", mmu_req, req_ready); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0; hold_data = 0;
    wait_ok(got, d);
    tot_cnt++; if (!got || d !== 32'h7777_0007)
      $display("FAIL cancel_first_ok got=%h (ok=%b) want=77770007", d, got); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ok) extra = 1;
      @(posedge clk); #1;
    end
    tot_cnt++; if (extra !== 1'b0 || occupancy !== 3'd0)
      $display("FAIL cancel_drained got=%b/%0d want=0/0", extra, occupancy); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit done, saw = 0;
    hold_data = 1; accept_ok = 1'b1;
    rd_src.push_back(32'h9999_9999);
    drive_op(LOAD_U, WORD, 32'h7000, 32'h0, 32'h0, done);
    req_valid = 1'b1;
    #3 reset = 1'b0;
    #1;
    tot_cnt++; if (occupancy !== 3'd0 || ok !== 1'b0 || mmu_req !== 1'b0)
      $display("FAIL async_reset got=%0d/%b/%b want=0/0/0", occupancy, ok, mmu_req); else pass_cnt++;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; hold_data = 0;
    rd_src.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ok || occupancy != 0) saw = 1;
      @(posedge clk); #1;
    end
    tot_cnt++; if (saw !== 1'b0) $display("FAIL async_reset_quiet got=%b want=0", saw); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_exceptions();
    test_back_to_back();
    test_extension();
    test_store();
    test_full();
    test_cancel();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached (passed %0d of %0d)", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule
